// File: rtl/dht11_pkg.sv
// Shared types and default timing for the DHT11 sensor emulator.
// Optional feature macro used by the emulator: DHT11_ERR_INJECT_EN.
package dht11_pkg;

    localparam int FRAME_BITS = 40;
    localparam int US_W       = 15;

    localparam int DEF_CLK_HZ       = 100_000_000;
    localparam int DEF_START_MIN_US = 18_000;
    localparam int DEF_RESP_WAIT_US = 30;
    localparam int DEF_RESP_LOW_US  = 80;
    localparam int DEF_RESP_HIGH_US = 80;
    localparam int DEF_BIT_LOW_US   = 50;
    localparam int DEF_BIT0_HIGH_US = 28;
    localparam int DEF_BIT1_HIGH_US = 70;

    typedef enum logic [2:0] {
        IDLE,
        HOST_LOW,
        HOST_REL,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } dht_state_t;

    // Checksum is the byte sum with carries dropped.
    function automatic logic [7:0] calc_chk(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [7:0] c,
        input logic [7:0] d
    );
        return a + b + c + d;
    endfunction

endpackage

// File: rtl/dht11_sensor_emu_us_tick_gen.sv
// Free-running divider producing a one-clock tick every microsecond.
module us_tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int DIV = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(DIV - 1));
    assign o_tick = w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dht11_sensor_emu.sv
// DHT11 sensor-side responder: host start detect, preamble, 40 data bits, end-low.
// Define DHT11_ERR_INJECT_EN to add the inj_err checksum-corruption input.
module dht11_sensor_emu
    import dht11_pkg::*;
#(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int START_MIN_US = DEF_START_MIN_US,
    parameter int RESP_WAIT_US = DEF_RESP_WAIT_US,
    parameter int RESP_LOW_US  = DEF_RESP_LOW_US,
    parameter int RESP_HIGH_US = DEF_RESP_HIGH_US,
    parameter int BIT_LOW_US   = DEF_BIT_LOW_US,
    parameter int BIT0_HIGH_US = DEF_BIT0_HIGH_US,
    parameter int BIT1_HIGH_US = DEF_BIT1_HIGH_US
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dht_in,
    output logic       dht_oe,
    output logic       dht_out,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] tmp_int,
    input  logic [7:0] tmp_dec,
`ifdef DHT11_ERR_INJECT_EN
    input  logic       inj_err,
`endif
    output logic       busy,
    output logic       frame_done,
    output logic       short_start
);

    localparam logic [US_W-1:0] L_START = US_W'(START_MIN_US);
    localparam logic [US_W-1:0] L_WAIT  = US_W'(RESP_WAIT_US);
    localparam logic [US_W-1:0] L_RL    = US_W'(RESP_LOW_US - 1);
    localparam logic [US_W-1:0] L_RH    = US_W'(RESP_HIGH_US - 1);
    localparam logic [US_W-1:0] L_BL    = US_W'(BIT_LOW_US - 1);
    localparam logic [US_W-1:0] L_B0    = US_W'(BIT0_HIGH_US - 1);
    localparam logic [US_W-1:0] L_B1    = US_W'(BIT1_HIGH_US - 1);
    localparam logic [5:0]      L_LAST  = 6'(FRAME_BITS - 1);

    logic                  w_tick;
    logic [1:0]            r_sync;
    logic                  r_prev;
    logic                  w_in;
    logic                  w_fall;
    logic                  w_rise;
    logic [7:0]            w_chk;
    logic [US_W-1:0]       w_bit_end;

    dht_state_t            r_state;
    logic [US_W-1:0]       r_us;
    logic [5:0]            r_bit;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_oe;
    logic                  r_out;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_short;

    us_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .i_clk   (clk),
        .i_rst_n (rst),
        .o_tick  (w_tick)
    );

    assign w_in   = r_sync[1];
    assign w_fall = r_prev & ~w_in;
    assign w_rise = ~r_prev & w_in;

`ifdef DHT11_ERR_INJECT_EN
    assign w_chk = calc_chk(hum_int, hum_dec, tmp_int, tmp_dec) ^ {7'd0, inj_err};
`else
    assign w_chk = calc_chk(hum_int, hum_dec, tmp_int, tmp_dec);
`endif

    assign w_bit_end = r_shift[FRAME_BITS-1] ? L_B1 : L_B0;

    assign dht_oe      = r_oe;
    assign dht_out     = r_out;
    assign busy        = r_busy;
    assign frame_done  = r_done;
    assign short_start = r_short;

    // Idle bus is pulled high, so the synchronizer resets to 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], dht_in};
            r_prev <= r_sync[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_us    <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_oe    <= 1'b0;
            r_out   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_short <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_short <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state <= HOST_LOW;
                        r_us    <= '0;
                    end
                end
                HOST_LOW: begin
                    if (w_rise) begin
                        r_us <= '0;
                        if (r_us >= L_START) begin
                            r_state <= HOST_REL;
                            r_busy  <= 1'b1;
                            r_shift <= {hum_int, hum_dec, tmp_int, tmp_dec, w_chk};
                        end else begin
                            r_state <= IDLE;
                            r_short <= 1'b1;
                        end
                    end else if (w_tick && r_us != '1) begin
                        r_us <= r_us + 1'b1;
                    end
                end
                // Release is not tick-aligned: one extra tick keeps the wait >= nominal.
                HOST_REL: begin
                    if (w_tick) begin
                        if (r_us == L_WAIT) begin
                            r_state <= RESP_LOW;
                            r_us    <= '0;
                            r_oe    <= 1'b1;
                            r_out   <= 1'b0;
                        end else begin
                            r_us <= r_us + 1'b1;
                        end
                    end
                end
                RESP_LOW: begin
                    if (w_tick) begin
                        if (r_us == L_RL) begin
                            r_state <= RESP_HIGH;
                            r_us    <= '0;
                            r_out   <= 1'b1;
                        end else begin
                            r_us <= r_us + 1'b1;
                        end
                    end
                end
                RESP_HIGH: begin
                    if (w_tick) begin
                        if (r_us == L_RH) begin
                            r_state <= BIT_LOW;
                            r_us    <= '0;
                            r_bit   <= '0;
                            r_out   <= 1'b0;
                        end else begin
                            r_us <= r_us + 1'b1;
                        end
                    end
                end
                BIT_LOW: begin
                    if (w_tick) begin
                        if (r_us == L_BL) begin
                            r_state <= BIT_HIGH;
                            r_us    <= '0;
                            r_out   <= 1'b1;
                        end else begin
                            r_us <= r_us + 1'b1;
                        end
                    end
                end
                BIT_HIGH: begin
                    if (w_tick) begin
                        if (r_us == w_bit_end) begin
                            r_state <= (r_bit == L_LAST) ? END_LOW : BIT_LOW;
                            r_us    <= '0;
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                            r_out   <= 1'b0;
                        end else begin
                            r_us <= r_us + 1'b1;
                        end
                    end
                end
                END_LOW: begin
                    if (w_tick) begin
                        if (r_us == L_BL) begin
                            r_state <= IDLE;
                            r_us    <= '0;
                            r_oe    <= 1'b0;
                            r_out   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_us <= r_us + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_oe    <= 1'b0;
                    r_out   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
